debug_trace_readout: RTL

//  Trigger-based trace buffer for the memcached debug path. It records per-cycle debug samples
//  (addr / nBytes / data, 64 b each) into an on-chip circular RAM. Once a capture completes, it streams
//  the stored samples out as 64-bit beats on a valid/ready port toward the host.
//  It does not feed a JTAG logic analyser: it gives the host software a readable copy of the same debug signals.

---
 rtl/debug_trace_pkg.sv | 47 ++++
 rtl/trace_ram_sdp.sv | 26 ++
 rtl/debug_trace_readout.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/debug_trace_pkg.sv
// Shared types and constants for the debug trace buffer.
// Optional feature macro: DEBUG_TRACE_TIMESTAMP_EN (adds a 64-bit timestamp beat per entry).
package debug_trace_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_POST  = 2'd2,
        S_READ  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        B_ADDR   = 2'd0,
        B_NBYTES = 2'd1,
        B_DATA   = 2'd2,
        B_TS     = 2'd3
    } beat_sel_t;

    localparam int BEAT_W = 64;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
    localparam int        BEATS_PER_ENTRY = 4;
    localparam beat_sel_t LAST_BEAT       = B_TS;
`else
    localparam int        BEATS_PER_ENTRY = 3;
    localparam beat_sel_t LAST_BEAT       = B_DATA;
`endif

    localparam int ENTRY_W = BEAT_W * BEATS_PER_ENTRY;

    // Entry layout, LSB first: addr, nbytes, data[, timestamp].
    function automatic logic [BEAT_W-1:0] beat_of(input logic [ENTRY_W-1:0] e,
                                                   input beat_sel_t s);
        logic [BEAT_W-1:0] b;
        case (s)
            B_ADDR:   b = e[1*BEAT_W-1:0*BEAT_W];
            B_NBYTES: b = e[2*BEAT_W-1:1*BEAT_W];
            B_DATA:   b = e[3*BEAT_W-1:2*BEAT_W];
`ifdef DEBUG_TRACE_TIMESTAMP_EN
            B_TS:     b = e[4*BEAT_W-1:3*BEAT_W];
`endif
            default:  b = '0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/trace_ram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle latency).
// A read of the address being written in the same cycle returns the new data.
module trace_ram_sdp
    import debug_trace_pkg::*;
#(
    parameter int DEPTH = 512,
    parameter int W     = ENTRY_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [W-1:0]  wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (re) q <= (we && (wa == ra)) ? wd : mem[ra];
    end

endmodule

// File: rtl/debug_trace_readout.sv
// Trigger-based trace buffer: captures debug samples into a circular RAM and streams them out.
// Optional feature macro: DEBUG_TRACE_TIMESTAMP_EN (stores a free-running cycle count per sample).
module debug_trace_readout
    import debug_trace_pkg::*;
#(
    parameter int DEPTH     = 512,
    parameter int POST_TRIG = 256
) (
    input  logic                     v_clk0,
    input  logic                     v_rst0,
    input  logic                     arm,
    input  logic                     trig,
    input  logic                     smp_valid,
    input  logic [63:0]              smp_addr,
    input  logic [63:0]              smp_nbytes,
    input  logic [63:0]              smp_data,
    output logic                     rd_valid,
    output logic [63:0]              rd_data,
    output logic                     rd_last,
    input  logic                     rd_ready,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   done_cnt
);

    localparam int             AW        = $clog2(DEPTH);
    localparam int             CW        = AW + 1;
    localparam logic [CW-1:0]  FULL      = CW'(DEPTH);
    localparam logic [AW-1:0]  POST_LAST = AW'(POST_TRIG - 1);

    // Readout handshake: a beat moves when rd_valid && rd_ready; while rd_valid is high and
    // rd_ready low, rd_data/rd_last hold, and rd_valid only falls after a transfer or on reset.

    state_t            state, state_nxt;
    logic [AW-1:0]     wr_ptr, post_cnt, rd_ptr, start_idx;
    logic [CW-1:0]     fill, fill_nxt, iss_left, load_left;
    logic              capture, restart, post_end;
    logic              issue_first, issue_more, ram_re, pend;
    logic [AW-1:0]     ram_ra;
    logic [ENTRY_W-1:0] ram_wd, ram_q, pf_ent, cur_ent, cur_src;
    logic              pf_vld, cur_vld, cur_final;
    beat_sel_t         cur_beat;
    logic              out_free, cur_take, cur_done, cur_load, pf_fill;

    // ---------------- capture FSM ----------------
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        restart   = 1'b0;
        post_end  = 1'b0;
        case (state)
            S_IDLE: begin
                if (arm) begin
                    state_nxt = S_ARMED;
                    restart   = 1'b1;
                end
            end
            S_ARMED: begin
                if (arm) begin
                    restart = 1'b1;
                end else begin
                    capture = smp_valid;
                    if (trig) begin
                        // The trigger sample, when present, opens the POST_TRIG window.
                        if (smp_valid && POST_TRIG == 1) begin
                            state_nxt = S_READ;
                            post_end  = 1'b1;
                        end else begin
                            state_nxt = S_POST;
                        end
                    end
                end
            end
            S_POST: begin
                capture = smp_valid;
                if (smp_valid && post_cnt == POST_LAST) begin
                    state_nxt = S_READ;
                    post_end  = 1'b1;
                end
            end
            S_READ: begin
                if (rd_valid && rd_ready && rd_last) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) state <= S_IDLE;
        else        state <= state_nxt;
    end

    assign busy      = (state != S_IDLE);
    assign fill_nxt  = (capture && fill != FULL) ? fill + 1'b1 : fill;
    // A full buffer is read from the slot after the newest write, i.e. the oldest entry.
    assign start_idx = (fill_nxt == FULL) ? wr_ptr + 1'b1 : '0;

`ifdef DEBUG_TRACE_TIMESTAMP_EN
    logic [63:0] ts_cnt;
    always_ff @(posedge v_clk0) begin
        if (v_rst0) ts_cnt <= '0;
        else        ts_cnt <= ts_cnt + 64'd1;
    end
    assign ram_wd = {ts_cnt, smp_data, smp_nbytes, smp_addr};
`else
    assign ram_wd = {smp_data, smp_nbytes, smp_addr};
`endif

    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            wr_ptr   <= '0;
            fill     <= '0;
            post_cnt <= '0;
            done_cnt <= '0;
        end else begin
            if (restart) begin
                wr_ptr <= '0;
                fill   <= '0;
            end else if (capture) begin
                wr_ptr <= wr_ptr + 1'b1;
                fill   <= fill_nxt;
            end
            if (state == S_ARMED && state_nxt == S_POST)
                post_cnt <= smp_valid ? AW'(1) : '0;
            else if (state == S_POST && capture)
                post_cnt <= post_cnt + 1'b1;
            if (post_end) done_cnt <= fill_nxt;
        end
    end

    // ---------------- RAM ----------------
    // The first read is issued on the capture-ending cycle so data is ready on READ entry.
    assign issue_first = post_end;
    assign issue_more  = (state == S_READ) && (iss_left != '0) && !pend && !pf_vld;
    assign ram_re      = issue_first || issue_more;
    assign ram_ra      = issue_first ? start_idx : rd_ptr;

    trace_ram_sdp #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .AW    (AW)
    ) u_ram (
        .clk (v_clk0),
        .we  (capture),
        .wa  (wr_ptr),
        .wd  (ram_wd),
        .re  (ram_re),
        .ra  (ram_ra),
        .q   (ram_q)
    );

    // ---------------- beat serializer ----------------
    // cur_ent is being serialized; pf_ent parks the next entry while cur_ent drains.
    always_comb begin
        out_free = !rd_valid || rd_ready;
        cur_take = out_free && cur_vld;
        cur_done = cur_take && (cur_beat == LAST_BEAT);
        cur_load = (state == S_READ) && (!cur_vld || cur_done) && (pf_vld || pend);
        cur_src  = pf_vld ? pf_ent : ram_q;
        pf_fill  = pend && !(cur_load && !pf_vld);
    end

    always_ff @(posedge v_clk0) begin
        if (v_rst0) begin
            pend      <= 1'b0;
            rd_ptr    <= '0;
            iss_left  <= '0;
            load_left <= '0;
            pf_vld    <= 1'b0;
            pf_ent    <= '0;
            cur_vld   <= 1'b0;
            cur_ent   <= '0;
            cur_beat  <= B_ADDR;
            cur_final <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            rd_last   <= 1'b0;
        end else begin
            pend <= ram_re;
            if (issue_first) begin
                rd_ptr    <= start_idx + 1'b1;
                iss_left  <= fill_nxt - 1'b1;
                load_left <= fill_nxt;
            end else if (issue_more) begin
                rd_ptr   <= rd_ptr + 1'b1;
                iss_left <= iss_left - 1'b1;
            end

            if (state != S_READ) begin
                cur_vld  <= 1'b0;
                pf_vld   <= 1'b0;
                rd_valid <= 1'b0;
                rd_last  <= 1'b0;
            end else begin
                if (cur_take) begin
                    rd_valid <= 1'b1;
                    rd_data  <= beat_of(cur_ent, cur_beat);
                    rd_last  <= cur_final && (cur_beat == LAST_BEAT);
                    cur_beat <= beat_sel_t'(cur_beat + 2'd1);
                end else if (out_free) begin
                    rd_valid <= 1'b0;
                    rd_last  <= 1'b0;
                end

                if (cur_load) begin
                    cur_ent   <= cur_src;
                    cur_vld   <= 1'b1;
                    cur_beat  <= B_ADDR;
                    cur_final <= (load_left == CW'(1));
                    load_left <= load_left - 1'b1;
                end else if (cur_done) begin
                    cur_vld <= 1'b0;
                end

                if (pf_fill) begin
                    pf_ent <= ram_q;
                    pf_vld <= 1'b1;
                end else if (cur_load && pf_vld) begin
                    pf_vld <= 1'b0;
                end
            end
        end
    end

endmodule
